// File: rtl/sel_pipe_reg_if.sv
// sel_pipe_reg_if: operand-select bus between a pipeline stage and sel_pipe_reg.
// Ports (master drives / slave receives):
//   en, clr, valid_in : stall, flush and operand-valid controls from the hazard unit
//   d, s              : N packed WIDTH-bit operands and the select index
//   y_next, y         : combinational and registered selected operand
//   valid_out, sel_err: registered valid bit and out-of-range-select flag
//   stall_cnt         : saturating count of stall cycles on the held valid operand
interface sel_pipe_reg_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N);
    logic               en;
    logic               clr;
    logic               valid_in;
    logic [N*WIDTH-1:0] d;
    logic [SW-1:0]      s;
    logic [WIDTH-1:0]   y_next;
    logic [WIDTH-1:0]   y;
    logic               valid_out;
    logic               sel_err;
    logic [7:0]         stall_cnt;
    modport master (
        output en, clr, valid_in, d, s,
        input  y_next, y, valid_out, sel_err, stall_cnt
    );
    modport slave (
        input  en, clr, valid_in, d, s,
        output y_next, y, valid_out, sel_err, stall_cnt
    );
endinterface

// File: rtl/sel_pipe_reg.sv
// sel_pipe_reg: N-way operand selector with a stall/flush pipeline register.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : sel_pipe_reg_if slave (en/clr/valid_in/d/s in; y_next/y/valid_out/sel_err/stall_cnt out)
module sel_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input logic         clk,
    input logic         reset,
    sel_pipe_reg_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d, y_next_c;
    logic             sel_err_q, sel_err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             in_range;
    // Selects at or beyond N (only possible when N is not a power of two) read as zero.
    assign in_range = int'(bus.s) < N;
    always_comb begin
        y_next_c = '0;
        for (int i = 0; i < N; i++)
            if (int'(bus.s) == i) y_next_c = bus.d[i*WIDTH +: WIDTH];
    end
    // Flush beats load beats stall; the counter only advances while a valid operand is held.
    always_comb begin
        y_d       = y_q;
        state_d   = state_q;
        sel_err_d = sel_err_q;
        cnt_d     = cnt_q;
        if (bus.clr) begin
            y_d       = '0;
            state_d   = EMPTY;
            sel_err_d = 1'b0;
            cnt_d     = 8'd0;
        end else if (bus.en) begin
            y_d       = y_next_c;
            cnt_d     = 8'd0;
            sel_err_d = !in_range;
            state_d   = (in_range && bus.valid_in) ? FULL : EMPTY;
        end else if (state_q == FULL && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q       <= '0;
            state_q   <= EMPTY;
            sel_err_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            y_q       <= y_d;
            state_q   <= state_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end
    assign bus.y_next    = y_next_c;
    assign bus.y         = y_q;
    assign bus.valid_out = (state_q == FULL);
    assign bus.sel_err   = sel_err_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_sel_pipe_reg.sv
// tb_sel_pipe_reg: four sel_pipe_reg configurations driven in lockstep against a behavioural model.
module tb_sel_pipe_reg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sel_pipe_reg_if #(.WIDTH(32), .N(4))  bus0 ();
    sel_pipe_reg_if #(.WIDTH(32), .N(3))  bus1 ();
    sel_pipe_reg_if #(.WIDTH(8),  .N(2))  bus2 ();
    sel_pipe_reg_if #(.WIDTH(64), .N(16)) bus3 ();
    sel_pipe_reg #(.WIDTH(32), .N(4))  u0 (.clk(clk), .reset(reset), .bus(bus0));
    sel_pipe_reg #(.WIDTH(32), .N(3))  u1 (.clk(clk), .reset(reset), .bus(bus1));
    sel_pipe_reg #(.WIDTH(8),  .N(2))  u2 (.clk(clk), .reset(reset), .bus(bus2));
    sel_pipe_reg #(.WIDTH(64), .N(16)) u3 (.clk(clk), .reset(reset), .bus(bus3));

    int W[4]   = '{32, 32, 8, 64};
    int NN[4]  = '{4, 3, 2, 16};
    int SWS[4] = '{2, 2, 1, 4};
    logic [1023:0] dv[4];
    logic [3:0]    sv[4];
    logic          en, clr, vin;
    logic [63:0]   my[4];
    logic          mv[4], me[4];
    int            mc[4];
    int            n_checks = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pick(input int i);
        logic [1023:0] t;
        if (int'(sv[i]) >= NN[i]) return 64'd0;
        t = dv[i] >> (int'(sv[i]) * W[i]);
        return (W[i] == 64) ? t[63:0] : (t[63:0] & ((64'd1 << W[i]) - 64'd1));
    endfunction

    task automatic obs(input int i, output logic [63:0] yn, output logic [63:0] yq,
                       output logic v, output logic e, output logic [7:0] c);
        case (i)
            0: begin yn = 64'(bus0.y_next); yq = 64'(bus0.y); v = bus0.valid_out; e = bus0.sel_err; c = bus0.stall_cnt; end
            1: begin yn = 64'(bus1.y_next); yq = 64'(bus1.y); v = bus1.valid_out; e = bus1.sel_err; c = bus1.stall_cnt; end
            2: begin yn = 64'(bus2.y_next); yq = 64'(bus2.y); v = bus2.valid_out; e = bus2.sel_err; c = bus2.stall_cnt; end
            default: begin yn = bus3.y_next; yq = bus3.y; v = bus3.valid_out; e = bus3.sel_err; c = bus3.stall_cnt; end
        endcase
    endtask

    task automatic drive();
        bus0.d = dv[0][127:0];  bus0.s = sv[0][1:0];
        bus1.d = dv[1][95:0];   bus1.s = sv[1][1:0];
        bus2.d = dv[2][15:0];   bus2.s = sv[2][0];
        bus3.d = dv[3];         bus3.s = sv[3];
        bus0.en = en; bus1.en = en; bus2.en = en; bus3.en = en;
        bus0.clr = clr; bus1.clr = clr; bus2.clr = clr; bus3.clr = clr;
        bus0.valid_in = vin; bus1.valid_in = vin; bus2.valid_in = vin; bus3.valid_in = vin;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 32; k++) dv[i][k*32 +: 32] = $urandom;
            sv[i] = 4'($urandom_range(0, (1 << SWS[i]) - 1));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            my[i] = 64'd0; mv[i] = 1'b0; me[i] = 1'b0; mc[i] = 0;
        end
    endtask

    task automatic check_state();
        logic [63:0] yn, yq;
        logic v, e;
        logic [7:0] c;
        for (int i = 0; i < 4; i++) begin
            obs(i, yn, yq, v, e, c);
            check($sformatf("y%0d", i), yq, my[i]);
            check($sformatf("valid_out%0d", i), 64'(v), 64'(mv[i]));
            check($sformatf("sel_err%0d", i), 64'(e), 64'(me[i]));
            check($sformatf("stall_cnt%0d", i), 64'(c), 64'(mc[i]));
        end
    endtask

    // One clock: drive, check the forwarding tap, step the model at the edge, check registers.
    task automatic cycle(input logic e_in, input logic c_in, input logic v_in);
        logic [63:0] yn, yq;
        logic v, e;
        logic [7:0] c;
        en = e_in; clr = c_in; vin = v_in;
        drive();
        #1;
        for (int i = 0; i < 4; i++) begin
            obs(i, yn, yq, v, e, c);
            check($sformatf("y_next%0d", i), yn, pick(i));
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (c_in) begin
                my[i] = 64'd0; mv[i] = 1'b0; me[i] = 1'b0; mc[i] = 0;
            end else if (e_in) begin
                my[i] = pick(i);
                mc[i] = 0;
                me[i] = int'(sv[i]) >= NN[i];
                mv[i] = !me[i] && v_in;
            end else if (mv[i] && mc[i] < 255) begin
                mc[i] = mc[i] + 1;
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        logic [63:0] yn, yq;
        logic v, e;
        logic [7:0] c;
        en = 1'b0; clr = 1'b0; vin = 1'b0;
        for (int i = 0; i < 4; i++) begin dv[i] = '0; sv[i] = 4'd0; end
        dv[0][127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
        sv[0] = 4'd2;
        drive();
        #3 reset = 1'b1;
        #1 model_reset();
        check_state();
        obs(0, yn, yq, v, e, c);
        check("y_next_in_reset", yn, 64'h33);
        #3 reset = 1'b0;

        cycle(1'b1, 1'b0, 1'b1);
        obs(0, yn, yq, v, e, c);
        check("first_y", yq, 64'h33);
        check("first_valid", 64'(v), 64'd1);
        check("first_sel_err", 64'(e), 64'd0);

        for (int i = 0; i < 4; i++) sv[i] = 4'd1;
        cycle(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            rand_inputs();
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        obs(0, yn, yq, v, e, c);
        check("stall_saturated", 64'(c), 64'd255);
        rand_inputs();
        cycle(1'b1, 1'b0, 1'b1);
        obs(0, yn, yq, v, e, c);
        check("stall_cleared", 64'(c), 64'd0);

        rand_inputs();
        cycle(1'b1, 1'b1, 1'b1);
        obs(0, yn, yq, v, e, c);
        check("flush_y", yq, 64'd0);
        check("flush_valid", 64'(v), 64'd0);
        check("flush_cnt", 64'(c), 64'd0);

        rand_inputs();
        sv[1] = 4'd3;
        cycle(1'b1, 1'b0, 1'b1);
        obs(1, yn, yq, v, e, c);
        check("oor_y", yq, 64'd0);
        check("oor_valid", 64'(v), 64'd0);
        check("oor_sel_err", 64'(e), 64'd1);
        sv[1] = 4'd1;
        cycle(1'b1, 1'b0, 1'b1);
        obs(1, yn, yq, v, e, c);
        check("oor_sel_err_cleared", 64'(e), 64'd0);

        rand_inputs();
        for (int i = 0; i < 4; i++) sv[i] = 4'd0;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        obs(0, yn, yq, v, e, c);
        check("invalid_valid", 64'(v), 64'd0);
        check("invalid_cnt", 64'(c), 64'd0);

        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1 model_reset();
        check_state();
        #1 reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        obs(0, yn, yq, v, e, c);
        check("post_reset_cnt", 64'(c), 64'd0);

        for (int k = 0; k < 16; k++) begin
            rand_inputs();
            sv[3] = 4'(k);
            sv[2] = 4'(k % 2);
            sv[1] = 4'(k % 4);
            sv[0] = 4'(k % 4);
            cycle(1'b1, 1'b0, 1'b1);
        end

        repeat (400) begin
            rand_inputs();
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sel_pipe_reg.md
# sel_pipe_reg

Parametrised N-way operand selector with a built-in pipeline register, for the pipelined CPU datapath (forwarding and result-select points between stages). It registers the selected input under the hazard unit's stall (`en`) and flush (`clr`) controls. It also tracks a valid bit, flags out-of-range selects, and counts how many cycles the held value has been stalled. It replaces a free-standing combinational mux followed by a separate enable/clear flop.

## Interface
Parameters:
- `WIDTH`, 32, data width of each input and of the output.
- `N`, 4, number of inputs (2..16). `SW = $clog2(N)` is derived, with a minimum of 1, and is not overridable.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `en`  input  1  load enable; low = stall (hold).
- `clr`  input  1  synchronous flush; inserts a bubble.
- `d`  input  N*WIDTH  packed inputs; input i is `d[i*WIDTH +: WIDTH]`.
- `s`  input  SW  select index.
- `valid_in`  input  1  the selected operand is valid this cycle.
- `y_next`  output  WIDTH  combinational selected value (same-cycle forwarding tap).
- `y`  output  WIDTH  registered selected value.
- `valid_out`  output  1  `y` holds a valid operand.
- `sel_err`  output  1  registered flag: the last load used `s >= N`.
- `stall_cnt`  output  8  consecutive stall cycles on the current valid value, saturating.

## Operation
- `y_next`:
  - equals `d[s]` when `s < N`;
  - equals 0 when `s >= N`, which is reachable only when N is not a power of two.
- Per rising edge, the highest-priority condition below wins:
  1. **Flush** (`clr`=1, regardless of `en`): `y`<=0, `valid_out`<=0, `sel_err`<=0, `stall_cnt`<=0.
  2. **Load** (`en`=1): `y`<=`y_next`, `stall_cnt`<=0.
     - When `s < N`: `valid_out`<=`valid_in`, `sel_err`<=0.
     - When `s >= N`: `valid_out`<=0, `sel_err`<=1.
  3. **Stall** (`en`=0): `y`, `valid_out` and `sel_err` hold their values.
     - `stall_cnt` increments by 1 when `valid_out`=1 and `stall_cnt`<255.
     - Otherwise `stall_cnt` holds.
- State machine with two states, derived from `valid_out`:
  - EMPTY (`valid_out`=0) moves to FULL on a Load with `valid_in`=1 and `s < N`.
  - FULL moves to EMPTY on a Flush, or on a Load with `valid_in`=0 or `s >= N`.
  - FULL stays FULL on a Stall.
  - EMPTY stays EMPTY on a Stall. `stall_cnt` stays at 0 while EMPTY.
- `stall_cnt` arithmetic is 8-bit unsigned. It saturates at 255 and never wraps.
- `sel_err` is purely informational and does not gate `y_next`.

## Timing
- Reset values while `reset`=1, asynchronous and independent of `clk`: `y`=0, `valid_out`=0, `sel_err`=0, `stall_cnt`=0.
- `y_next` is still driven from `d` and `s` during reset.
- Reset deasserted mid-stall: the block comes out EMPTY with the counter at 0. Nothing from before reset is retained.
- Latency:
  - `d`/`s` to `y`: 1 cycle when `en`=1.
  - `d`/`s` to `y_next`: 0 cycles (combinational).
- `clr` and `en` both high: Flush wins, and the register takes the bubble.
- A stall of K cycles on a valid value gives `stall_cnt`=min(K,255) at the edge ending the K-th stall cycle.
- The first Load after a stall clears `stall_cnt` on that edge.
- There is no combinational path from `en`, `clr` or `valid_in` to any output.

## Test plan
- **Reset and first load.** Stimulus: `reset` pulse mid-cycle; then N=4, `d`={0x44,0x33,0x22,0x11} (input 3..0), `s`=2, `en`=1, `valid_in`=1. Required response:
  - outputs go to 0 asynchronously during the pulse;
  - after one edge, `y`=0x33, `valid_out`=1, `sel_err`=0;
  - `y_next`=0x33 in the same cycle as the stimulus.
- **Stall and saturation.** Stimulus: after a valid load, hold `en`=0 for 300 cycles while `d`/`s` change. Required response:
  - `y` is unchanged throughout;
  - `stall_cnt` reads 1,2,…,255 and then stays at 255;
  - the next Load returns `stall_cnt` to 0.
- **Flush priority.** Stimulus: `clr`=1 and `en`=1 on the same edge, with `valid_in`=1. Required response: `y`=0, `valid_out`=0, `stall_cnt`=0.
- **Out-of-range select.** Stimulus: N=3, `s`=3, `en`=1, `valid_in`=1. Required response:
  - `y_next`=0;
  - after the edge, `y`=0, `valid_out`=0, `sel_err`=1;
  - a following load with `s`=1 clears `sel_err`.
- **Invalid operand.** Stimulus: Load with `valid_in`=0, then stall 5 cycles. Required response: `valid_out`=0 and `stall_cnt` stays 0.
- **Width/N sweep.** Stimulus: WIDTH=8/N=2 and WIDTH=64/N=16, each index selected with a random value. Required response: `y` matches `d[s]` one cycle after every Load.
